// File: rtl/trng_pkg.sv
// Shared constants for the TRNG byte packer: default FIFO depth, health-test limit and byte width.
// No logic; no latency; no backpressure.
// Optional Von Neumann debiasing is selected in the top by TRNG_VN_DEBIAS_EN.
package trng_pkg;
    localparam int TRNG_FIFO_DEPTH_DEFAULT = 4;
    localparam int TRNG_REP_LIMIT_DEFAULT  = 16;
    localparam int TRNG_BYTE_W             = 8;
endpackage

// File: rtl/trng_fifo.sv
// First-word-fall-through byte FIFO with flush; head is shown on rdata while not empty, else zero.
// Latency: a push is visible on rdata the cycle after the pushing edge.
// Backpressure: push is ignored when full unless a pop happens on the same edge.
module trng_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          wr_en;
    logic          rd_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign rd_en = pop && !empty;
    // When full, the popped slot is the one being overwritten, so a same-edge push is safe.
    assign wr_en = push && (!full || rd_en);
    assign rdata = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + PW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/trng_byte_packer.sv
// Raw entropy bits -> repetition health test -> optional Von Neumann debias (TRNG_VN_DEBIAS_EN) -> MSB-first bytes -> FIFO.
// Latency: byte_valid the cycle after the edge sampling the bit that completes a byte.
// Backpressure: FIFO drained by byte_valid/byte_ready; a completed byte with FIFO full and no pop is dropped with an overflow pulse.
module trng_byte_packer
    import trng_pkg::*;
#(
    parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH_DEFAULT,
    parameter int REP_LIMIT  = TRNG_REP_LIMIT_DEFAULT,
    localparam int CW        = $clog2(FIFO_DEPTH) + 1,
    localparam int RUN_W     = $clog2(REP_LIMIT + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    output logic [TRNG_BYTE_W-1:0] byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic [CW-1:0]          fill_level,
    output logic                   overflow,
    output logic                   health_fail
);
    logic                   accept;
    logic                   prev_bit;
    logic                   have_prev;
    logic [RUN_W-1:0]       run;
    logic [RUN_W-1:0]       run_nxt;
    logic                   fail_now;
    logic                   emit_vld;
    logic                   emit_bit;
    logic [TRNG_BYTE_W-2:0] part;
    logic [TRNG_BYTE_W-1:0] byte_nxt;
    logic [2:0]             bit_cnt;
    logic                   byte_done;
    logic                   push_req;
    logic                   pop;
    logic                   drop;
    logic                   fifo_full;
    logic                   fifo_empty;

    assign accept = bit_valid && !health_fail;

    always_comb begin
        run_nxt = RUN_W'(1);
        if (have_prev && (bit_in == prev_bit)) begin
            if (run == RUN_W'(REP_LIMIT))
                run_nxt = run;
            else
                run_nxt = run + RUN_W'(1);
        end
    end

    assign fail_now = accept && (run_nxt == RUN_W'(REP_LIMIT));

`ifdef TRNG_VN_DEBIAS_EN
    logic pair_full;
    logic pair_bit;

    // Only unequal pairs emit, and the emitted value is the first bit of the pair.
    assign emit_vld = accept && pair_full && (pair_bit != bit_in);
    assign emit_bit = pair_bit;

    always_ff @(posedge clk) begin
        if (reset || fail_now) begin
            pair_full <= 1'b0;
            pair_bit  <= 1'b0;
        end else if (accept) begin
            pair_full <= !pair_full;
            if (!pair_full)
                pair_bit <= bit_in;
        end
    end
`else
    assign emit_vld = accept;
    assign emit_bit = bit_in;
`endif

    assign byte_nxt  = {part, emit_bit};
    assign byte_done = emit_vld && (bit_cnt == 3'd7);
    assign pop       = byte_valid && byte_ready;
    // A byte completing on the failing edge is discarded along with the flush.
    assign push_req  = byte_done && !fail_now;
    assign drop      = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_bit    <= 1'b0;
            have_prev   <= 1'b0;
            run         <= '0;
            health_fail <= 1'b0;
            part        <= '0;
            bit_cnt     <= '0;
            overflow    <= 1'b0;
        end else begin
            overflow <= drop;
            if (accept) begin
                prev_bit  <= bit_in;
                have_prev <= 1'b1;
                run       <= run_nxt;
            end
            if (fail_now) begin
                health_fail <= 1'b1;
                part        <= '0;
                bit_cnt     <= '0;
            end else if (emit_vld) begin
                part    <= byte_nxt[TRNG_BYTE_W-2:0];
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    trng_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (TRNG_BYTE_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .flush (fail_now),
        .wdata (byte_nxt),
        .rdata (byte_out),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fill_level)
    );

    assign byte_valid = !fifo_empty;
endmodule

// File: doc/trng_byte_packer.md
# trng_byte_packer

Consumes the single raw random bit produced each cycle by the SR-latch entropy network and turns it into a stream of bytes for the rest of the chip. It runs a repetition-count health test on the raw bits and, optionally, Von Neumann debiasing. It packs the surviving bits MSB-first into bytes and buffers them in a small FIFO. The FIFO is drained over a valid/ready handshake. The block sits directly downstream of the latch network and upstream of any byte consumer (output pins, UART, test logic).

## Interface
- FIFO_DEPTH, 4: byte FIFO depth; power of two, at least 2.
- REP_LIMIT, 16: number of consecutive identical raw bits that triggers a health failure; at least 2.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- bit_in  in  1  raw entropy bit.
- bit_valid  in  1  bit_in is sampled on this cycle's rising edge.
- byte_out  out  8  FIFO head byte; valid only while byte_valid=1.
- byte_valid  out  1  FIFO not empty.
- byte_ready  in  1  consumer accepts byte_out this cycle.
- fill_level  out  $clog2(FIFO_DEPTH)+1  number of bytes in the FIFO.
- overflow  out  1  one-cycle pulse: a completed byte was dropped.
- health_fail  out  1  sticky repetition-test failure.

## Operation
- Reset values: byte_valid=0, fill_level=0, overflow=0, health_fail=0, byte_out=0.
- Reset also clears the packer bit count, the partial byte, the debias pair state, the run counter and the FIFO pointers.
- Health test (raw bits, before debiasing):
  - On each accepted bit, run becomes 1 if bit_in differs from the previous raw bit (or on the first bit after reset); otherwise run increments.
  - run is $clog2(REP_LIMIT+1) bits wide and saturates at REP_LIMIT.
  - When run reaches REP_LIMIT, health_fail is set on that edge.
- Failed state:
  - On the edge that sets health_fail, the FIFO is flushed (fill_level=0) and the partial byte is cleared.
  - While health_fail=1, bits are ignored and byte_valid stays 0.
  - Only reset clears health_fail.
- Packer:
  - Each emitted bit shifts into an 8-bit register, MSB-first: the first bit emitted lands in byte_out[7].
  - A 3-bit counter tracks the fill; the wrap from 7 to 0 completes a byte.
- Push:
  - A completed byte is written to the FIFO on the same edge as its 8th bit.
  - If the FIFO is full and no pop occurs on that edge, the byte is discarded, overflow pulses for one cycle and the FIFO is unchanged.
- Pop: occurs when byte_valid && byte_ready. The FIFO is first-word-fall-through, so the next entry appears on byte_out in the following cycle.
- Simultaneous push and pop:
  - Both are performed on the same edge; fill_level is unchanged.
  - This holds even when the FIFO is full, in which case no overflow occurs.
- Simultaneous health failure and pop: the flush takes priority.

## Timing
- Debias off: a byte is visible (byte_valid=1) in the cycle after the edge that samples its 8th accepted raw bit.
- Debias on:
  - Latency is counted from the edge that samples the second bit of the pair producing the 8th debiased bit.
  - The next cycle has byte_valid=1.
- health_fail rises in the cycle after the edge sampling the REP_LIMIT-th identical bit.
- overflow is high for exactly the cycle following the dropping edge.
- fill_level reflects the state after each edge; there are no combinational paths from inputs to outputs.

## Configuration
- TRNG_VN_DEBIAS_EN defined: accepted raw bits are paired.
  - The first bit of a pair is held; the second completes the pair.
  - Pair 10 emits 1 and pair 01 emits 0 (the first bit is emitted). Pairs 00 and 11 emit nothing.
  - Pair state is cleared by reset and on health failure.
- TRNG_VN_DEBIAS_EN undefined: every accepted raw bit goes directly to the packer.
- The health test operates on raw bits in both builds.

## Structure
- Package trng_pkg holds:
  - defaults TRNG_FIFO_DEPTH_DEFAULT=4 and TRNG_REP_LIMIT_DEFAULT=16;
  - the byte width constant TRNG_BYTE_W=8.
- Sub-module trng_fifo is a parameterised FWFT FIFO with push, pop, flush, full, empty and count.
- Health test, debiaser and packer stay in the top module.

## Test plan
- Debias off, byte_ready=1, bits 1,0,1,1,0,0,1,0 on consecutive cycles -> byte_out=8'hB2 with byte_valid=1 for exactly one cycle, the cycle after the 8th bit.
- Debias on, raw pairs 10,01,11,10,10,00,01,01,10,01 -> byte_out=8'hB2; 11 and 00 emit nothing; latency is one cycle after the last pair.
- byte_ready=0, push 5 bytes with alternating-pattern bits (e.g. 8'h55) -> fill_level=4 and overflow pulses once on the 5th. Then byte_ready=1 drains the first four bytes in order, with fill_level counting down 4,3,2,1,0.
- FIFO full, byte_ready=1 held as the next byte completes -> push and pop on the same edge, fill_level stays 4, overflow=0.
- 16 consecutive raw 1s -> health_fail=1 the cycle after the 16th; byte_valid=0 and fill_level=0 (the earlier 8'hFF is flushed). Further bits are ignored until reset, which clears health_fail.
- Reset asserted after 5 of 8 bits -> partial byte discarded; the next 8 bits 1,0,1,0,1,0,1,0 produce byte_out=8'hAA.
